// File: rtl/lv_efuse_ctrl_pkg.sv
// lv_efuse_ctrl_pkg: shared lv efuse controller defaults and state encoding.
package lv_efuse_ctrl_pkg;
    localparam int LV_EFUSE_WORD_NUM = 8;
    localparam int LV_EFUSE_DATA_W   = 8;
    localparam int LV_EFUSE_STRB_CYC = 4;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, DONE} efuse_state_e;
endpackage

// File: rtl/lv_efuse_ctrl.sv
// lv_efuse_ctrl: sequential efuse word loader with register-bank writeback and XOR checksum.
module lv_efuse_ctrl
    import lv_efuse_ctrl_pkg::*;
#(
    parameter int EFUSE_WORD_NUM = LV_EFUSE_WORD_NUM,
    parameter int EFUSE_DATA_W   = LV_EFUSE_DATA_W,
    parameter int EFUSE_STRB_CYC = LV_EFUSE_STRB_CYC
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_power_on,
    input  logic                              i_fsm_efuse_load_en,
    output logic                              o_efuse_fsm_load_done,
    output logic                              o_efuse_cs,
    output logic [$clog2(EFUSE_WORD_NUM)-1:0] o_efuse_addr,
    output logic                              o_efuse_rd_strb,
    input  logic [EFUSE_DATA_W-1:0]           i_efuse_rdata,
    output logic                              o_reg_wr_en,
    output logic [$clog2(EFUSE_WORD_NUM)-1:0] o_reg_wr_addr,
    output logic [EFUSE_DATA_W-1:0]           o_reg_wr_data,
    output logic                              o_efuse_busy,
    output logic                              o_efuse_chk_err
);
    localparam int AW = $clog2(EFUSE_WORD_NUM);
    localparam logic [AW-1:0] LAST_IDX = AW'(EFUSE_WORD_NUM - 1);
    localparam logic [3:0] LAST_CNT = 4'(EFUSE_STRB_CYC - 1);

    efuse_state_e state, next;
    logic [AW-1:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [EFUSE_DATA_W-1:0] acc;
    logic start, sel, capture;

    always_comb begin
        next = state;
        idx_nxt = idx;
        cnt_nxt = cnt;
        case (state)
            IDLE: if (i_fsm_efuse_load_en) begin
                next = SETUP;
                idx_nxt = '0;
            end
            SETUP: begin
                next = STROBE;
                cnt_nxt = '0;
            end
            STROBE: if (cnt == LAST_CNT) next = CAPTURE; else cnt_nxt = cnt + 4'd1;
            CAPTURE: if (idx == LAST_IDX) next = DONE; else begin
                next = SETUP;
                idx_nxt = idx + AW'(1);
            end
            default: next = IDLE;
        endcase
        if (!i_power_on) next = IDLE;
    end

    assign start = state == IDLE && next == SETUP;
    assign sel = next == SETUP || next == STROBE || next == CAPTURE;
    assign capture = state == CAPTURE && i_power_on;

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            acc <= '0;
            o_efuse_cs <= 1'b0;
            o_efuse_rd_strb <= 1'b0;
            o_efuse_addr <= '0;
            o_efuse_busy <= 1'b0;
            o_efuse_fsm_load_done <= 1'b0;
            o_reg_wr_en <= 1'b0;
            o_reg_wr_addr <= '0;
            o_reg_wr_data <= '0;
            o_efuse_chk_err <= 1'b0;
        end else begin
            state <= next;
            idx <= idx_nxt;
            cnt <= cnt_nxt;
            o_efuse_cs <= sel;
            o_efuse_rd_strb <= next == STROBE;
            o_efuse_addr <= sel ? idx_nxt : '0;
            o_efuse_busy <= next != IDLE;
            o_efuse_fsm_load_done <= next == DONE;
            o_reg_wr_en <= capture;
            if (capture) begin
                o_reg_wr_addr <= idx;
                o_reg_wr_data <= i_efuse_rdata;
            end
            acc <= start ? '0 : capture ? acc ^ i_efuse_rdata : acc;
            // acc holds words 0..N-2 while the last word is on the bus
            o_efuse_chk_err <= start ? 1'b0 : (capture && next == DONE) ? acc != i_efuse_rdata : o_efuse_chk_err;
        end
    end
endmodule
